mem_address_gen: RTL and testbench

- Parametrised playback address generator for the flash audio path; owns the sample address register.
- Advances the address once per request from the sample interpreter, with forward/backward direction, programmable stride, pause, restart, and loop or one-shot end handling.
- Sits between the flash read sequencer/data interpreter and the flash read port, and replaces the fixed-width single-step address updater.

---
 rtl/mem_addr_pkg.sv | 18 +
 rtl/mem_addr_next.sv | 59 +++++
 rtl/mem_address_gen.sv | 118 +++++++++++
 tb/tb_mem_address_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_addr_pkg.sv
// Shared types and default constants for the flash playback address generator.
package mem_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } addr_state_t;

    localparam int DEF_ADDR_W     = 23;
    localparam int DEF_START_ADDR = 0;
    localparam int DEF_END_ADDR   = 524287;
    localparam int DEF_STEP_W     = 4;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_BWD = 1'b0;

endpackage

// File: rtl/mem_addr_next.sv
// Combinational next-address calculation: stride, window edge detection and wrap target.
module mem_addr_next
    import mem_addr_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int START_ADDR = DEF_START_ADDR,
    parameter int END_ADDR   = DEF_END_ADDR,
    parameter int STEP_W     = DEF_STEP_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              direction,
    input  logic              loop_en,
    input  logic [STEP_W-1:0] step,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap,
    output logic              edge_hit
);

    localparam logic [ADDR_W:0]   START_EXT = (ADDR_W+1)'(START_ADDR);
    localparam logic [ADDR_W:0]   END_EXT   = (ADDR_W+1)'(END_ADDR);
    localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(END_ADDR);

    logic [ADDR_W:0] addr_ext;
    logic [ADDR_W:0] stride;
    logic [ADDR_W:0] fwd_sum;
    logic [ADDR_W:0] bwd_diff;
    logic [ADDR_W:0] bwd_floor;
    logic            in_window;
    logic            fits;

    // One extra bit keeps addr + stride from overflowing before the edge compare.
    always_comb begin
        addr_ext  = {1'b0, addr};
        stride    = (step == '0) ? (ADDR_W+1)'(1) : (ADDR_W+1)'(step);
        fwd_sum   = addr_ext + stride;
        bwd_diff  = addr_ext - stride;
        bwd_floor = START_EXT + stride;
        in_window = (addr_ext >= START_EXT) && (addr_ext <= END_EXT);

        if (direction == DIR_FWD) begin
            fits = in_window && (fwd_sum <= END_EXT);
        end else begin
            fits = in_window && (addr_ext >= bwd_floor);
        end

        edge_hit = !fits;
        wrap     = !fits && loop_en;

        if (fits) begin
            next_addr = (direction == DIR_FWD) ? fwd_sum[ADDR_W-1:0] : bwd_diff[ADDR_W-1:0];
        end else if (direction == DIR_BWD) begin
            next_addr = loop_en ? END_A : START_A;
        end else begin
            next_addr = loop_en ? START_A : END_A;
        end
    end

endmodule

// File: rtl/mem_address_gen.sv
// Playback address generator: owns the sample address register and the req/ack handshake FSM.
module mem_address_gen
    import mem_addr_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int START_ADDR = DEF_START_ADDR,
    parameter int END_ADDR   = DEF_END_ADDR,
    parameter int STEP_W     = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              direction,
    input  logic              pause,
    input  logic              restart,
    input  logic              loop_en,
    input  logic [STEP_W-1:0] step,
    output logic [ADDR_W-1:0] addr,
    output logic              ack,
    output logic              wrapped,
    output logic              done
);

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

    if (!((START_ADDR < END_ADDR) && (longint'(END_ADDR) < (longint'(1) << ADDR_W))
          && (STEP_W <= ADDR_W))) begin : g_bad_params
        $error("mem_address_gen: need START_ADDR < END_ADDR < 2**ADDR_W and STEP_W <= ADDR_W");
    end

    addr_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] nx_addr;
    logic              nx_wrap;
    logic              nx_edge;

    mem_addr_next #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR),
        .STEP_W     (STEP_W)
    ) u_next (
        .addr      (addr_q),
        .direction (direction),
        .loop_en   (loop_en),
        .step      (step),
        .next_addr (nx_addr),
        .wrap      (nx_wrap),
        .edge_hit  (nx_edge)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= START_A;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    // done is latched with the edge-hitting update so it rises together with that ack.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wrap_d  = wrap_q;
        done_d  = done_q;

        if (restart) begin
            state_d = IDLE;
            addr_d  = (direction == DIR_FWD) ? START_A : END_A;
            wrap_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = ACK;
                        wrap_d  = 1'b0;
                        if (!pause) begin
                            addr_d = nx_addr;
                            wrap_d = nx_wrap;
                            if (nx_edge && !loop_en) begin
                                done_d = 1'b1;
                            end
                        end
                    end
                end
                ACK: begin
                    state_d = done_q ? DONE : IDLE;
                end
                DONE: begin
                    if (req) begin
                        state_d = ACK;
                        wrap_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign addr    = addr_q;
    assign ack     = (state_q == ACK);
    assign wrapped = (state_q == ACK) && wrap_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_address_gen.sv
// Scoreboard bench for mem_address_gen with an 8-bit address window of 16..31.
module tb_mem_address_gen;

    logic       clk;
    logic       reset_n;
    logic       req;
    logic       direction;
    logic       pause;
    logic       restart;
    logic       loop_en;
    logic [3:0] step;
    logic [7:0] addr;
    logic       ack;
    logic       wrapped;
    logic       done;

    typedef struct {
        logic [7:0] addr;
        logic       wrapped;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_address_gen #(
        .ADDR_W     (8),
        .START_ADDR (16),
        .END_ADDR   (31),
        .STEP_W     (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .direction (direction),
        .pause     (pause),
        .restart   (restart),
        .loop_en   (loop_en),
        .step      (step),
        .addr      (addr),
        .ack       (ack),
        .wrapped   (wrapped),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && ack) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack=1 addr=%0d, expected no ack at %0t", addr, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_addr", int'(addr), int'(e.addr));
                check("sb_wrapped", int'(wrapped), int'(e.wrapped));
                check("sb_done", int'(done), int'(e.done));
            end
        end else if (reset_n && wrapped) begin
            n_checks++;
            n_fail++;
            $display("FAIL wrapped_without_ack: got wrapped=1, expected 0 at %0t", $time);
        end
    end

    // Called at posedge+1; leaves the bench at posedge+1 two edges later.
    task automatic do_req(input logic [7:0] ea, input logic ew, input logic ed);
        exp_t e;
        e.addr    = ea;
        e.wrapped = ew;
        e.done    = ed;
        exp_q.push_back(e);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("ack_latency", int'(ack), 1);
        @(posedge clk); #1;
        check("ack_one_cycle", int'(ack), 0);
    endtask

    task automatic do_restart(input logic dir);
        direction = dir;
        restart   = 1'b1;
        @(posedge clk); #1;
        restart   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req       = 1'b0;
        direction = 1'b1;
        pause     = 1'b0;
        restart   = 1'b0;
        loop_en   = 1'b0;
        step      = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", int'(addr), 16);
        check("rst_ack", int'(ack), 0);
        check("rst_wrapped", int'(wrapped), 0);
        check("rst_done", int'(done), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Forward single steps
        do_req(8'd17, 1'b0, 1'b0);
        do_req(8'd18, 1'b0, 1'b0);
        do_req(8'd19, 1'b0, 1'b0);

        // Reach 30, then forward wrap with loop
        step = 4'd11;
        do_req(8'd30, 1'b0, 1'b0);
        step    = 4'd4;
        loop_en = 1'b1;
        do_req(8'd16, 1'b1, 1'b0);

        // Backward one-shot edge
        loop_en = 1'b0;
        do_restart(1'b0);
        check("restart_bwd_addr", int'(addr), 31);
        check("restart_no_ack", int'(ack), 0);
        step = 4'd8;
        do_req(8'd23, 1'b0, 1'b0);
        do_req(8'd16, 1'b0, 1'b1);
        do_req(8'd16, 1'b0, 1'b1);
        check("done_level", int'(done), 1);

        // Backward wrap with loop
        do_restart(1'b0);
        check("restart_clears_done", int'(done), 0);
        loop_en = 1'b1;
        do_req(8'd23, 1'b0, 1'b0);
        do_req(8'd31, 1'b1, 1'b0);

        // Pause and zero stride
        loop_en = 1'b0;
        do_restart(1'b1);
        check("restart_fwd_addr", int'(addr), 16);
        step = 4'd4;
        do_req(8'd20, 1'b0, 1'b0);
        pause = 1'b1;
        do_req(8'd20, 1'b0, 1'b0);
        pause = 1'b0;
        step  = 4'd0;
        do_req(8'd21, 1'b0, 1'b0);

        // Forward one-shot edge, then restart beats a simultaneous req
        step = 4'd15;
        do_req(8'd31, 1'b0, 1'b1);
        check("fwd_done_level", int'(done), 1);
        direction = 1'b1;
        req       = 1'b1;
        restart   = 1'b1;
        @(posedge clk); #1;
        req     = 1'b0;
        restart = 1'b0;
        check("prio_addr", int'(addr), 16);
        check("prio_done", int'(done), 0);
        check("prio_no_ack", int'(ack), 0);
        @(posedge clk); #1;
        check("prio_still_no_ack", int'(ack), 0);

        // Asynchronous reset during ACK
        step = 4'd1;
        req  = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("pre_reset_ack", int'(ack), 1);
        check("pre_reset_addr", int'(addr), 17);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_ack", int'(ack), 0);
        check("async_rst_addr", int'(addr), 16);
        check("async_rst_done", int'(done), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(8'd17, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
